// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with combinational read ports,
// one synchronous write port, a hardwired-zero register and a pending-write
// scoreboard that reports a per-port Busy flag.
// Optional feature: define REGFILE_BYPASS_EN to forward the in-flight write
// data (and clear Busy) to any read port addressing the register being written.
module regfile_param #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_IDX = (2 ** ADDR_W) - 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteRegister,
  input  logic [WIDTH-1:0]         WriteData,
  input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
  output logic [NUM_RD*WIDTH-1:0]  ReadData,
  input  logic                     SetBusy,
  input  logic [ADDR_W-1:0]        SetBusyReg,
  output logic [NUM_RD-1:0]        Busy
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic [WIDTH-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0] pending_r;
  logic [DEPTH-1:0] pending_next_s;
  logic             wr_en_s;

  // Writes to the hardwired-zero register are dropped before they reach storage.
  assign wr_en_s = RegWrite & (WriteRegister != ZERO_ADDR);

  // Register storage: async clear, single write port on the rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_r[WriteRegister] <= WriteData;
    end
  end

  // Scoreboard next state: a write retires the pending bit, an issue sets it,
  // and the issue wins when both target the same register in one cycle.
  always_comb begin
    pending_next_s = pending_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (SetBusy && (SetBusyReg == ADDR_W'(i)) && (ADDR_W'(i) != ZERO_ADDR)) begin
        pending_next_s[i] = 1'b1;
      end else if (RegWrite && (WriteRegister == ADDR_W'(i))) begin
        pending_next_s[i] = 1'b0;
      end else begin
        pending_next_s[i] = pending_r[i];
      end
    end
  end

  // Scoreboard register with async clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_next_s;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] addr_s;
    logic              fwd_s;
    logic [WIDTH-1:0]  data_s;
    logic              busy_s;

    assign addr_s = ReadRegister[k*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so every lane reads zero.
    assign fwd_s = RegWrite & ~reset & (WriteRegister == addr_s);
`else
    assign fwd_s = 1'b0;
`endif

    // Read lane: zero register, then forwarded write, then stored value.
    always_comb begin
      data_s = '0;
      busy_s = 1'b0;
      if (addr_s == ZERO_ADDR) begin
        data_s = '0;
        busy_s = 1'b0;
      end else if (fwd_s) begin
        data_s = WriteData;
        busy_s = 1'b0;
      end else begin
        data_s = regs_r[addr_s];
        busy_s = pending_r[addr_s];
      end
    end

    assign ReadData[k*WIDTH +: WIDTH] = data_s;
    assign Busy[k]                    = busy_s;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus randomized
// traffic against a behavioural array model of registers and pending flags.
module tb_regfile_param;

  localparam int          W  = 64;
  localparam int          AW = 5;
  localparam int          NR = 2;
  localparam int          D  = 32;
  localparam logic [4:0]  ZA = 5'd31;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              RegWrite;
  logic [AW-1:0]     WriteRegister;
  logic [W-1:0]      WriteData;
  logic [NR*AW-1:0]  ReadRegister;
  logic [NR*W-1:0]   ReadData;
  logic              SetBusy;
  logic [AW-1:0]     SetBusyReg;
  logic [NR-1:0]     Busy;

  logic              rw4;
  logic [4:0]        wr4;
  logic [31:0]       wd4;
  logic [19:0]       rr4;
  logic [127:0]      rd4;
  logic              sb4;
  logic [4:0]        sbr4;
  logic [3:0]        busy4;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_mem  [D];
  bit           m_pend [D];

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(W), .ADDR_W(AW), .NUM_RD(NR), .ZERO_IDX(31)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister(ReadRegister), .ReadData(ReadData),
    .SetBusy(SetBusy), .SetBusyReg(SetBusyReg), .Busy(Busy)
  );

  regfile_param #(.WIDTH(32), .ADDR_W(5), .NUM_RD(4)) dut4 (
    .clk(clk), .reset(reset), .RegWrite(rw4), .WriteRegister(wr4),
    .WriteData(wd4), .ReadRegister(rr4), .ReadData(rd4),
    .SetBusy(sb4), .SetBusyReg(sbr4), .Busy(busy4)
  );

  function automatic logic [W-1:0] exp_data(input logic [4:0] a);
    if (a == ZA) return '0;
    if (reset) return '0;
    if (BYP && RegWrite && (WriteRegister == a)) return WriteData;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == ZA) return 1'b0;
    if (reset) return 1'b0;
    if (BYP && RegWrite && (WriteRegister == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_clear;
    for (int i = 0; i < D; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic tick;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (RegWrite && (WriteRegister != ZA)) m_mem[WriteRegister] = WriteData;
      if (RegWrite) m_pend[WriteRegister] = 1'b0;
      if (SetBusy && (SetBusyReg != ZA)) m_pend[SetBusyReg] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs;
    RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    SetBusy = 1'b0; SetBusyReg = '0; ReadRegister = '0;
    rw4 = 1'b0; wr4 = '0; wd4 = '0; rr4 = '0; sb4 = 1'b0; sbr4 = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    model_clear();
    // write and issue attempts during reset must be ignored
    RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 64'h0123_4567_89AB_CDEF;
    SetBusy = 1'b1; SetBusyReg = 5'd4;
    tick();
    tick();
    idle_inputs();
    for (int a = 0; a < D; a++) begin
      ReadRegister = {5'(a), 5'(a)};
      #1;
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (ReadData[k*W +: W] !== 64'd0 || Busy[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_read addr=%0d port=%0d data=%h busy=%b required data=0 busy=0",
                   a, k, ReadData[k*W +: W], Busy[k]);
        end
      end
    end
    reset = 1'b0;
    ReadRegister = {5'd4, 5'd0};
    @(negedge clk);
    checks++;
    if (ReadData !== 128'd0 || Busy !== 2'b00) begin
      errors++;
      $display("FAIL after_reset data=%h busy=%b required 0/0", ReadData, Busy);
    end
    tick();
  endtask

  task automatic test_write_read;
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hDEADBEEF_CAFEF00D;
    tick();
    RegWrite = 1'b0;
    ReadRegister = {5'd5, 5'd5};
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (ReadData[k*W +: W] !== 64'hDEADBEEF_CAFEF00D) begin
        errors++;
        $display("FAIL write_read port=%0d got=%h required=%h", k, ReadData[k*W +: W],
                 64'hDEADBEEF_CAFEF00D);
      end
    end
    tick();
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'h1234;
    tick();
    RegWrite = 1'b0;
    ReadRegister = {5'd5, 5'd31};
    @(negedge clk);
    checks++;
    if (ReadData[63:0] !== 64'd0) begin
      errors++;
      $display("FAIL zero_reg got=%h required=0", ReadData[63:0]);
    end
    checks++;
    if (ReadData[127:64] !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL zero_reg_side got=%h required=%h", ReadData[127:64], 64'hDEADBEEF_CAFEF00D);
    end
    tick();
  endtask

  task automatic test_same_cycle;
    logic [W-1:0] want;
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h33;
    tick();
    WriteData = 64'hAA;
    ReadRegister = {5'd0, 5'd7};
    @(negedge clk);
    want = BYP ? 64'hAA : 64'h33;
    checks++;
    if (ReadData[63:0] !== want) begin
      errors++;
      $display("FAIL same_cycle got=%h required=%h", ReadData[63:0], want);
    end
    tick();
    RegWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (ReadData[63:0] !== 64'hAA) begin
      errors++;
      $display("FAIL after_write got=%h required=%h", ReadData[63:0], 64'hAA);
    end
    tick();
  endtask

  task automatic test_busy;
    SetBusy = 1'b1; SetBusyReg = 5'd3;
    tick();
    SetBusy = 1'b0;
    ReadRegister = {5'd3, 5'd0};
    @(negedge clk);
    checks++;
    if (Busy !== 2'b10) begin
      errors++;
      $display("FAIL busy_set got=%b required=%b", Busy, 2'b10);
    end
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'h77;
    #1;
    checks++;
    if (Busy[1] !== (BYP ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL busy_write_cycle got=%b required=%b", Busy[1], !BYP);
    end
    tick();
    RegWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (Busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL busy_clear got=%b required=0", Busy[1]);
    end
    SetBusy = 1'b1; SetBusyReg = 5'd3;
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'h88;
    tick();
    SetBusy = 1'b0; RegWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (Busy[1] !== 1'b1 || ReadData[127:64] !== 64'h88) begin
      errors++;
      $display("FAIL busy_set_priority busy=%b data=%h required busy=1 data=88", Busy[1],
               ReadData[127:64]);
    end
    SetBusy = 1'b1; SetBusyReg = 5'd31;
    tick();
    SetBusy = 1'b0;
    ReadRegister = {5'd31, 5'd31};
    @(negedge clk);
    checks++;
    if (Busy !== 2'b00) begin
      errors++;
      $display("FAIL busy_zero_reg got=%b required=00", Busy);
    end
    tick();
  endtask

  task automatic test_async_reset;
    RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h55;
    SetBusy = 1'b1; SetBusyReg = 5'd9;
    tick();
    SetBusy = 1'b0;
    WriteData = 64'h66;
    ReadRegister = {5'd9, 5'd9};
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (ReadData[k*W +: W] !== 64'd0 || Busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset port=%0d data=%h busy=%b required 0/0", k,
                 ReadData[k*W +: W], Busy[k]);
      end
    end
    tick();
    reset = 1'b0;
    RegWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (ReadData !== 128'd0 || Busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_discard data=%h busy=%b required 0/0", ReadData, Busy);
    end
    tick();
  endtask

  task automatic test_four_port;
    logic [31:0] want [4];
    want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h11; want[3] = 32'h0;
    rw4 = 1'b1; wr4 = 5'd0; wd4 = 32'h11;
    tick();
    wr4 = 5'd1; wd4 = 32'h22;
    tick();
    rw4 = 1'b0;
    rr4 = {5'd31, 5'd0, 5'd1, 5'd0};
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd4[k*32 +: 32] !== want[k] || busy4[k] !== 1'b0) begin
        errors++;
        $display("FAIL four_port lane=%0d got=%h busy=%b required=%h busy=0", k,
                 rd4[k*32 +: 32], busy4[k], want[k]);
      end
    end
    tick();
  endtask

  task automatic test_random;
    logic [4:0] a;
    for (int n = 0; n < 400; n++) begin
      RegWrite      = ($urandom_range(0, 1) == 1);
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData     = {$urandom, $urandom};
      SetBusy       = ($urandom_range(0, 2) == 0);
      SetBusyReg    = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister  = {5'($urandom_range(0, 31)),
                       ($urandom_range(0, 2) == 0) ? WriteRegister : 5'($urandom_range(0, 31))};
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        a = ReadRegister[k*AW +: AW];
        checks++;
        if (ReadData[k*W +: W] !== exp_data(a) || Busy[k] !== exp_busy(a)) begin
          errors++;
          $display("FAIL random n=%0d port=%0d addr=%0d data=%h busy=%b required data=%h busy=%b",
                   n, k, a, ReadData[k*W +: W], Busy[k], exp_data(a), exp_busy(a));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_cycle();
    test_busy();
    test_async_reset();
    test_four_port();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
